// File: rtl/countdown_timer_pkg.sv
// ============================================================================
// countdown_timer_pkg : shared state encoding and defaults for countdown_timer
// Revision: 1.0
// ============================================================================
`default_nettype none

package countdown_timer_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam int DEFAULT_WIDTH    = 8;
   localparam int DEFAULT_PRESCALE = 1;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      RUN   = ST_RUN,
      PAUSE = ST_PAUSE,
      DONE  = ST_DONE
   } state_t;

   function automatic logic is_busy(input state_t s);
      return (s == RUN) || (s == PAUSE);
   endfunction

endpackage

`default_nettype wire

// File: rtl/countdown_timer_tick_prescaler.sv
// ============================================================================
// tick_prescaler : emits one tick every PRESCALE un-held cycles; phase holds
//                  while hold is high and returns to zero on clr.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tick_prescaler #(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic hold,
   output logic tick
);

   generate
      if (PRESCALE <= 1) begin : g_passthru
         // No phase state needed: every un-held cycle is a tick.
         logic unused_inputs;
         assign unused_inputs = clk ^ rst ^ clr;
         assign tick          = ~hold;
      end else begin : g_count
         localparam int            PW   = $clog2(PRESCALE);
         localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

         logic [PW-1:0] phase;

         assign tick = ~hold && (phase == LAST);

         always_ff @(posedge clk) begin
            if (rst || clr) begin
               phase <= '0;
            end else if (!hold) begin
               phase <= tick ? '0 : phase + PW'(1);
            end
         end
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/countdown_timer.sv
// ============================================================================
// countdown_timer : loadable prescaled down-counter with done pulse and sticky
//                   expiry flag. Define TIMER_RELOAD_EN for periodic reload.
// Revision: 1.0
// ============================================================================
`default_nettype none

module countdown_timer
   import countdown_timer_pkg::*;
#(
   parameter int WIDTH    = DEFAULT_WIDTH,
   parameter int PRESCALE = DEFAULT_PRESCALE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             pause,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             expired
);

   state_t           state;
   logic [WIDTH-1:0] shadow;
   logic             tick;
   logic             hold;
   logic             last_tick;
   logic             start_empty;

   // Prescaler only advances in RUN when not being paused or reloaded.
   assign hold      = (state != RUN) || pause || load;
   assign last_tick = (count <= WIDTH'(1));

`ifdef TIMER_RELOAD_EN
   assign start_empty = (count == '0) || (shadow == '0);
`else
   assign start_empty = (count == '0);
   logic unused_shadow;
   assign unused_shadow = ^shadow;
`endif

   tick_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .clr  (load),
      .hold (hold),
      .tick (tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         count   <= '0;
         shadow  <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         expired <= 1'b0;
      end else begin
         done <= 1'b0;
         if (load) begin
            state   <= IDLE;
            count   <= load_val;
            shadow  <= load_val;
            busy    <= 1'b0;
            expired <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     if (start_empty) begin
                        state   <= DONE;
                        busy    <= is_busy(DONE);
                        done    <= 1'b1;
                        expired <= 1'b1;
                     end else begin
                        state <= RUN;
                        busy  <= is_busy(RUN);
                     end
                  end
               end
               RUN: begin
                  if (pause) begin
                     state <= PAUSE;
                     busy  <= is_busy(PAUSE);
                  end else if (tick) begin
                     if (last_tick) begin
                        done    <= 1'b1;
                        expired <= 1'b1;
`ifdef TIMER_RELOAD_EN
                        if (shadow != '0) begin
                           count <= shadow;
                        end else begin
                           count <= '0;
                           state <= DONE;
                           busy  <= is_busy(DONE);
                        end
`else
                        count <= '0;
                        state <= DONE;
                        busy  <= is_busy(DONE);
`endif
                     end else begin
                        count <= count - WIDTH'(1);
                     end
                  end
               end
               PAUSE: begin
                  if (start && !pause) begin
                     state <= RUN;
                     busy  <= is_busy(RUN);
                  end
               end
               DONE: begin
                  // Terminal until load or rst; count stays at zero.
                  count <= '0;
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_countdown_timer.sv
// ============================================================================
// tb_countdown_timer : directed self-checking bench for countdown_timer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_countdown_timer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       load = 1'b0, start = 1'b0, pause = 1'b0;
   logic [7:0] load_val = 8'd0;
   logic [7:0] count;
   logic       busy, done, expired;

   logic       load4 = 1'b0, start4 = 1'b0, pause4 = 1'b0;
   logic [7:0] load_val4 = 8'd0;
   logic [7:0] count4;
   logic       busy4, done4, expired4;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   countdown_timer #(.WIDTH(8), .PRESCALE(1)) dut (
      .clk(clk), .rst(rst), .load(load), .load_val(load_val),
      .start(start), .pause(pause),
      .count(count), .busy(busy), .done(done), .expired(expired)
   );

   countdown_timer #(.WIDTH(8), .PRESCALE(4)) dut4 (
      .clk(clk), .rst(rst), .load(load4), .load_val(load_val4),
      .start(start4), .pause(pause4),
      .count(count4), .busy(busy4), .done(done4), .expired(expired4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock edge; outputs are sampled on the following falling edge.
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_flags(input string tag, input logic [7:0] c, input logic b,
                              input logic d, input logic e);
      check({tag, ".count"}, 32'(count), 32'(c));
      check({tag, ".busy"}, 32'(busy), 32'(b));
      check({tag, ".done"}, 32'(done), 32'(d));
      check({tag, ".expired"}, 32'(expired), 32'(e));
   endtask

   initial begin
      // 1: reset held two cycles
      cyc(); cyc();
      check_flags("reset", 8'd0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;

`ifndef TIMER_RELOAD_EN
      // 2: load 5, count down every cycle
      load = 1'b1; load_val = 8'd5; cyc(); load = 1'b0;
      check_flags("load5", 8'd5, 1'b0, 1'b0, 1'b0);
      start = 1'b1; cyc(); start = 1'b0;
      check_flags("start5", 8'd5, 1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         cyc();
         check_flags($sformatf("run5_%0d", i), 8'(5 - i), 1'b1, 1'b0, 1'b0);
      end
      cyc();
      check_flags("expire5", 8'd0, 1'b0, 1'b1, 1'b1);
      cyc();
      check_flags("after5", 8'd0, 1'b0, 1'b0, 1'b1);
      start = 1'b1; cyc(); start = 1'b0;
      check_flags("done_start_ignored", 8'd0, 1'b0, 1'b0, 1'b1);

      // 3: load 6, pause at 3, resume; done 10 edges after first start
      load = 1'b1; load_val = 8'd6; cyc(); load = 1'b0;
      check("load6.expired_cleared", 32'(expired), 32'd0);
      start = 1'b1; cyc(); start = 1'b0;
      cyc(); cyc(); cyc();
      check_flags("run6_at3", 8'd3, 1'b1, 1'b0, 1'b0);
      pause = 1'b1; cyc();
      check_flags("pause6_a", 8'd3, 1'b1, 1'b0, 1'b0);
      cyc();
      check_flags("pause6_b", 8'd3, 1'b1, 1'b0, 1'b0);
      start = 1'b1; cyc();
      check_flags("pause6_start_and_pause", 8'd3, 1'b1, 1'b0, 1'b0);
      pause = 1'b0; cyc(); start = 1'b0;
      check_flags("resume6", 8'd3, 1'b1, 1'b0, 1'b0);
      cyc();
      check_flags("resume6_2", 8'd2, 1'b1, 1'b0, 1'b0);
      cyc();
      check_flags("resume6_1", 8'd1, 1'b1, 1'b0, 1'b0);
      cyc();
      check_flags("expire6", 8'd0, 1'b0, 1'b1, 1'b1);
`else
      // 6: periodic reload, load 3 -> 2,1,3,2,1,3
      load = 1'b1; load_val = 8'd3; cyc(); load = 1'b0;
      start = 1'b1; cyc(); start = 1'b0;
      check_flags("rl_start", 8'd3, 1'b1, 1'b0, 1'b0);
      cyc(); check_flags("rl_2a", 8'd2, 1'b1, 1'b0, 1'b0);
      cyc(); check_flags("rl_1a", 8'd1, 1'b1, 1'b0, 1'b0);
      cyc(); check_flags("rl_3a", 8'd3, 1'b1, 1'b1, 1'b1);
      cyc(); check_flags("rl_2b", 8'd2, 1'b1, 1'b0, 1'b1);
      cyc(); check_flags("rl_1b", 8'd1, 1'b1, 1'b0, 1'b1);
      cyc(); check_flags("rl_3b", 8'd3, 1'b1, 1'b1, 1'b1);
      load = 1'b1; load_val = 8'd7; cyc(); load = 1'b0;
      check_flags("rl_load7", 8'd7, 1'b0, 1'b0, 1'b0);
      cyc();
      check_flags("rl_idle7", 8'd7, 1'b0, 1'b0, 1'b0);
`endif

      // 4: load 0 then start -> immediate DONE, single pulse
      load = 1'b1; load_val = 8'd0; cyc(); load = 1'b0;
      start = 1'b1; cyc(); start = 1'b0;
      check_flags("zero_start", 8'd0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 20; i++) begin
         cyc();
         check($sformatf("zero_hold_count_%0d", i), 32'(count), 32'd0);
         check($sformatf("zero_hold_done_%0d", i), 32'(done), 32'd0);
      end
      load = 1'b1; load_val = 8'd2; cyc(); load = 1'b0;
      check_flags("load2_clears", 8'd2, 1'b0, 1'b0, 1'b0);

      // 5a: PRESCALE=4, load 3 -> done exactly 12 edges after start
      load4 = 1'b1; load_val4 = 8'd3; cyc(); load4 = 1'b0;
      start4 = 1'b1; cyc(); start4 = 1'b0;
      check("ps4.start_busy", 32'(busy4), 32'd1);
      for (int k = 1; k <= 11; k++) begin
         cyc();
         check($sformatf("ps4.done_low_%0d", k), 32'(done4), 32'd0);
         if (k == 3) check("ps4.count_k3", 32'(count4), 32'd3);
         if (k == 4) check("ps4.count_k4", 32'(count4), 32'd2);
         if (k == 7) check("ps4.count_k7", 32'(count4), 32'd2);
         if (k == 8) check("ps4.count_k8", 32'(count4), 32'd1);
      end
      cyc();
      check("ps4.done_k12", 32'(done4), 32'd1);
      check("ps4.expired_k12", 32'(expired4), 32'd1);
`ifndef TIMER_RELOAD_EN
      check("ps4.count_k12", 32'(count4), 32'd0);
`else
      check("ps4.count_k12", 32'(count4), 32'd3);
`endif
      cyc();
      check("ps4.done_k13", 32'(done4), 32'd0);

      // 5b: load 200, start, reset mid-run at count 100
      load = 1'b1; load_val = 8'd200; cyc(); load = 1'b0;
      start = 1'b1; cyc(); start = 1'b0;
      for (int i = 0; i < 100; i++) cyc();
      check_flags("run200_at100", 8'd100, 1'b1, 1'b0, 1'b0);
      rst = 1'b1; start = 1'b1; cyc(); rst = 1'b0; start = 1'b0;
      check_flags("rst_midrun", 8'd0, 1'b0, 1'b0, 1'b0);
      check("rst_midrun.ps4_count", 32'(count4), 32'd0);
      cyc();
      check_flags("post_rst_idle", 8'd0, 1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

`default_nettype wire
